pipe_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core. Generates hold/flush for pc, if_id and id_ex from

---
 rtl/pipe_ctrl_pkg.sv | 57 +++++
 rtl/pipe_ctrl_hazard_detect.sv | 27 ++
 rtl/pipe_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Purpose : shared types for the pipeline sequencer: FSM state encoding,
//           the per-cycle control bundle and helpers that build common
//           control patterns.
// Ports   : none (package).
package pipe_ctrl_pkg;

  localparam int unsigned PC_ADDR_W = 32;
  localparam int unsigned PC_REG_AW = 5;
  localparam int unsigned PC_PERF_W = 32;

  // Sequencer states, 2-bit encoding.
  typedef enum logic [1:0] {
    PC_ST_RUN      = 2'd0,
    PC_ST_HOLD     = 2'd1,
    PC_ST_JMP_PEND = 2'd2,
    PC_ST_HALT     = 2'd3
  } pc_state_e;

  // Control bundle driven to pc / if_id / id_ex for one cycle.
  typedef struct packed {
    logic pc_hold;
    logic if_id_hold;
    logic if_id_flush;
    logic id_ex_flush;
    logic jump_en;
    logic halted;
  } pipe_ctl_t;

  // Front end frozen; optionally bubble id_ex.
  function automatic pipe_ctl_t ctl_stall(input logic flush_ex);
    pipe_ctl_t c;
    c             = '0;
    c.pc_hold     = 1'b1;
    c.if_id_hold  = 1'b1;
    c.id_ex_flush = flush_ex;
    return c;
  endfunction

  // Redirect pc and kill the two younger instructions.
  function automatic pipe_ctl_t ctl_redirect();
    pipe_ctl_t c;
    c             = '0;
    c.if_id_flush = 1'b1;
    c.id_ex_flush = 1'b1;
    c.jump_en     = 1'b1;
    return c;
  endfunction

  // Parked after ebreak.
  function automatic pipe_ctl_t ctl_halted();
    pipe_ctl_t c;
    c        = ctl_stall(1'b1);
    c.halted = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Purpose : combinational load-use detector. Flags when the load in ex
//           writes a register the instruction in id reads; x0 never hazards.
// Ports   : ex_is_load_i  in  1       ex holds a load
//           ex_rd_addr_i  in  REG_AW  destination of the load
//           id_rs1_addr_i in  REG_AW  first source in id
//           id_rs2_addr_i in  REG_AW  second source in id
//           load_use_o    out 1       stall one cycle
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = PC_REG_AW
) (
  input  logic              ex_is_load_i,
  input  logic [REG_AW-1:0] ex_rd_addr_i,
  input  logic [REG_AW-1:0] id_rs1_addr_i,
  input  logic [REG_AW-1:0] id_rs2_addr_i,
  output logic              load_use_o
);

  logic w_rd_nz;
  logic w_rs_match;

  assign w_rd_nz    = |ex_rd_addr_i;
  assign w_rs_match = (ex_rd_addr_i == id_rs1_addr_i) || (ex_rd_addr_i == id_rs2_addr_i);
  assign load_use_o = ex_is_load_i && w_rd_nz && w_rs_match;

endmodule

// File: rtl/pipe_ctrl.sv
// Purpose : pipeline sequencer for the 5-stage core. Turns halt, ex-resolved
//           jumps, external hold and load-use into hold/flush controls for
//           pc, if_id and id_ex. A jump seen during an external hold is
//           latched and replayed once the hold drops.
// Options : PIPE_CTRL_PERF_EN adds saturating stall/flush cycle counters.
// Ports   : clk, rst (sync, active high)
//           jump_en_i, jump_addr_i[ADDR_W]  taken branch/jump from ex
//           hold_req_i                       external busy
//           halt_req_i                       ebreak in ex
//           id_rs1_addr_i, id_rs2_addr_i     sources in id
//           ex_is_load_i, ex_rd_addr_i       load destination in ex
//           pc_hold_o, if_id_hold_o, if_id_flush_o, id_ex_flush_o
//           jump_en_o, jump_addr_o[ADDR_W]   pc redirect
//           halted_o                         sticky halt
//           stall_cnt_o, flush_cnt_o[PERF_W] (PIPE_CTRL_PERF_EN only)
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = PC_ADDR_W,
  parameter int unsigned REG_AW = PC_REG_AW,
  parameter int unsigned PERF_W = PC_PERF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              hold_req_i,
  input  logic              halt_req_i,
  input  logic [REG_AW-1:0] id_rs1_addr_i,
  input  logic [REG_AW-1:0] id_rs2_addr_i,
  input  logic              ex_is_load_i,
  input  logic [REG_AW-1:0] ex_rd_addr_i,
  output logic              pc_hold_o,
  output logic              if_id_hold_o,
  output logic              if_id_flush_o,
  output logic              id_ex_flush_o,
  output logic              jump_en_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              halted_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o
`endif
);

  pc_state_e         r_state;
  pc_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [ADDR_W-1:0] w_jump_addr;
  logic              w_latch;
  logic              w_load_use;
  pipe_ctl_t         w_ctl;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .ex_is_load_i  (ex_is_load_i),
    .ex_rd_addr_i  (ex_rd_addr_i),
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .load_use_o    (w_load_use)
  );

  // State and pending-jump registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= PC_ST_RUN;
      r_pend_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_pend_addr <= jump_addr_i;
      end
    end
  end

  // Next state and same-cycle controls; priority halt > jump > hold > load-use.
  always_comb begin
    w_state_nxt = r_state;
    w_ctl       = '0;
    w_jump_addr = '0;
    w_latch     = 1'b0;
    if (rst) begin
      w_state_nxt = PC_ST_RUN;
    end else if (halt_req_i && (r_state != PC_ST_HALT)) begin
      // Any pending jump is simply abandoned.
      w_ctl       = ctl_stall(1'b1);
      w_state_nxt = PC_ST_HALT;
    end else begin
      case (r_state)
        // HOLD releases with exactly the RUN rules, so both share one arm.
        PC_ST_RUN, PC_ST_HOLD: begin
          if (jump_en_i && hold_req_i) begin
            w_ctl       = ctl_stall(1'b0);
            w_latch     = 1'b1;
            w_state_nxt = PC_ST_JMP_PEND;
          end else if (jump_en_i) begin
            w_ctl       = ctl_redirect();
            w_jump_addr = jump_addr_i;
            w_state_nxt = PC_ST_RUN;
          end else if (hold_req_i) begin
            w_ctl       = ctl_stall(1'b0);
            w_state_nxt = PC_ST_HOLD;
          end else if (w_load_use) begin
            w_ctl       = ctl_stall(1'b1);
            w_state_nxt = PC_ST_RUN;
          end else begin
            w_state_nxt = PC_ST_RUN;
          end
        end
        // First latched jump wins; new jumps and load-use are ignored here.
        PC_ST_JMP_PEND: begin
          if (hold_req_i) begin
            w_ctl = ctl_stall(1'b0);
          end else begin
            w_ctl       = ctl_redirect();
            w_jump_addr = r_pend_addr;
            w_state_nxt = PC_ST_RUN;
          end
        end
        PC_ST_HALT: begin
          w_ctl = ctl_halted();
        end
        default: begin
          w_state_nxt = PC_ST_RUN;
        end
      endcase
    end
  end

  assign pc_hold_o     = w_ctl.pc_hold;
  assign if_id_hold_o  = w_ctl.if_id_hold;
  assign if_id_flush_o = w_ctl.if_id_flush;
  assign id_ex_flush_o = w_ctl.id_ex_flush;
  assign jump_en_o     = w_ctl.jump_en;
  assign jump_addr_o   = w_jump_addr;
  assign halted_o      = w_ctl.halted;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] r_stall_cnt;
  logic [PERF_W-1:0] r_flush_cnt;

  // Saturating cycle counters, frozen once halted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (r_state != PC_ST_HALT) begin
      if (w_ctl.pc_hold && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + PERF_W'(1);
      end
      if (w_ctl.id_ex_flush && !(&r_flush_cnt)) begin
        r_flush_cnt <= r_flush_cnt + PERF_W'(1);
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  logic [PERF_W-1:0] w_perf_unused;
  assign w_perf_unused = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Purpose : self-checking bench for pipe_ctrl: directed vector table,
//           hand-written halt and counter sequences, then random stimulus
//           against a flag-based reference model.
module tb_pipe_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned PW = 4;

  logic          clk;
  logic          rst;
  logic          jump_en_i;
  logic [AW-1:0] jump_addr_i;
  logic          hold_req_i;
  logic          halt_req_i;
  logic [RW-1:0] id_rs1_addr_i;
  logic [RW-1:0] id_rs2_addr_i;
  logic          ex_is_load_i;
  logic [RW-1:0] ex_rd_addr_i;
  logic          pc_hold_o;
  logic          if_id_hold_o;
  logic          if_id_flush_o;
  logic          id_ex_flush_o;
  logic          jump_en_o;
  logic [AW-1:0] jump_addr_o;
  logic          halted_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [PW-1:0] stall_cnt_o;
  logic [PW-1:0] flush_cnt_o;
`endif

  pipe_ctrl #(
    .ADDR_W (AW),
    .REG_AW (RW),
    .PERF_W (PW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .jump_en_i     (jump_en_i),
    .jump_addr_i   (jump_addr_i),
    .hold_req_i    (hold_req_i),
    .halt_req_i    (halt_req_i),
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .ex_is_load_i  (ex_is_load_i),
    .ex_rd_addr_i  (ex_rd_addr_i),
    .pc_hold_o     (pc_hold_o),
    .if_id_hold_o  (if_id_hold_o),
    .if_id_flush_o (if_id_flush_o),
    .id_ex_flush_o (id_ex_flush_o),
    .jump_en_o     (jump_en_o),
    .jump_addr_o   (jump_addr_o),
    .halted_o      (halted_o)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          rst;
    logic          jump;
    logic          hold;
    logic          halt;
    logic          load;
    logic [AW-1:0] jaddr;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [RW-1:0] rd;
  } in_t;

  typedef struct packed {
    logic          pc_hold;
    logic          if_id_hold;
    logic          if_id_flush;
    logic          id_ex_flush;
    logic          jump_en;
    logic          halted;
    logic [AW-1:0] jaddr;
  } out_t;

  typedef struct {
    in_t   i;
    out_t  e;
    string nm;
  } vec_t;

  int n_err = 0;
  int n_chk = 0;

  // Reference model: core is either halted, has one pending jump, or is free.
  bit            m_halted;
  bit            m_pend;
  logic [AW-1:0] m_pend_addr;
  int            m_stall;
  int            m_flush;
  bit            m_synced;

  function automatic in_t mk_in(input logic r, input logic j, input logic h, input logic ht,
                                input logic ld, input logic [AW-1:0] a,
                                input int s1, input int s2, input int d);
    in_t v;
    v.rst = r; v.jump = j; v.hold = h; v.halt = ht; v.load = ld; v.jaddr = a;
    v.rs1 = RW'(s1); v.rs2 = RW'(s2); v.rd = RW'(d);
    return v;
  endfunction

  function automatic out_t mk_out(input logic ph, input logic ih, input logic iflu,
                                  input logic eflu, input logic je, input logic hl,
                                  input logic [AW-1:0] a);
    out_t o;
    o.pc_hold = ph; o.if_id_hold = ih; o.if_id_flush = iflu; o.id_ex_flush = eflu;
    o.jump_en = je; o.halted = hl; o.jaddr = a;
    return o;
  endfunction

  function automatic out_t model_eval(input in_t v);
    bit lu;
    lu = v.load && (v.rd != 0) && ((v.rd == v.rs1) || (v.rd == v.rs2));
    if (v.rst)             return mk_out(0, 0, 0, 0, 0, 0, '0);
    else if (m_halted)     return mk_out(1, 1, 0, 1, 0, 1, '0);
    else if (v.halt)       return mk_out(1, 1, 0, 1, 0, 0, '0);
    else if (m_pend)       return v.hold ? mk_out(1, 1, 0, 0, 0, 0, '0)
                                         : mk_out(0, 0, 1, 1, 1, 0, m_pend_addr);
    else if (v.jump)       return v.hold ? mk_out(1, 1, 0, 0, 0, 0, '0)
                                         : mk_out(0, 0, 1, 1, 1, 0, v.jaddr);
    else if (v.hold)       return mk_out(1, 1, 0, 0, 0, 0, '0);
    else if (lu)           return mk_out(1, 1, 0, 1, 0, 0, '0);
    return mk_out(0, 0, 0, 0, 0, 0, '0);
  endfunction

  task automatic model_step(input in_t v, input out_t e);
    int cap;
    cap = (1 << PW) - 1;
    if (v.rst) begin
      m_halted = 0; m_pend = 0; m_pend_addr = '0;
      m_stall = 0; m_flush = 0; m_synced = 1;
    end else begin
      if (!m_halted) begin
        if (e.pc_hold && m_stall < cap)     m_stall = m_stall + 1;
        if (e.id_ex_flush && m_flush < cap) m_flush = m_flush + 1;
      end
      if (m_halted) begin
      end else if (v.halt) begin
        m_halted = 1; m_pend = 0;
      end else if (m_pend) begin
        if (!v.hold) m_pend = 0;
      end else if (v.jump && v.hold) begin
        m_pend = 1; m_pend_addr = v.jaddr;
      end
    end
  endtask

  // Drive one cycle, check combinational outputs before the edge, advance.
  task automatic run_cycle(input in_t v, input out_t exp, input string nm);
    out_t act;
    rst           = v.rst;
    jump_en_i     = v.jump;
    hold_req_i    = v.hold;
    halt_req_i    = v.halt;
    ex_is_load_i  = v.load;
    jump_addr_i   = v.jaddr;
    id_rs1_addr_i = v.rs1;
    id_rs2_addr_i = v.rs2;
    ex_rd_addr_i  = v.rd;
    #1;
    act = mk_out(pc_hold_o, if_id_hold_o, if_id_flush_o, id_ex_flush_o,
                 jump_en_o, halted_o, jump_addr_o);
    // The redirect address only matters while a redirect is expected.
    if (!exp.jump_en) act.jaddr = exp.jaddr;
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t: got ph/ih/if/ef/je/ht=%b addr=%h, expected %b addr=%h",
               nm, $time, act[AW+5:AW], act.jaddr, exp[AW+5:AW], exp.jaddr);
    end
`ifdef PIPE_CTRL_PERF_EN
    if (m_synced && !v.rst) begin
      n_chk++;
      if (stall_cnt_o !== PW'(m_stall) || flush_cnt_o !== PW'(m_flush)) begin
        n_err++;
        $display("FAIL %s_cnt t=%0t: got stall=%0d flush=%0d, expected stall=%0d flush=%0d",
                 nm, $time, stall_cnt_o, flush_cnt_o, m_stall, m_flush);
      end
    end
`endif
    model_step(v, model_eval(v));
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[24];

  initial begin
    in_t  v;
    out_t o0, ost, osb, oht;
    m_halted = 0; m_pend = 0; m_pend_addr = '0; m_stall = 0; m_flush = 0; m_synced = 0;
    rst = 1'b1; jump_en_i = 0; jump_addr_i = '0; hold_req_i = 0; halt_req_i = 0;
    id_rs1_addr_i = '0; id_rs2_addr_i = '0; ex_is_load_i = 0; ex_rd_addr_i = '0;

    o0  = mk_out(0, 0, 0, 0, 0, 0, '0);
    ost = mk_out(1, 1, 0, 0, 0, 0, '0);
    osb = mk_out(1, 1, 0, 1, 0, 0, '0);
    oht = mk_out(1, 1, 0, 1, 0, 1, '0);

    tbl[0]  = '{mk_in(1, 0, 0, 0, 0, '0, 0, 0, 0), o0, "reset"};
    tbl[1]  = '{mk_in(0, 1, 0, 0, 0, 32'h8000_0040, 0, 0, 0),
                mk_out(0, 0, 1, 1, 1, 0, 32'h8000_0040), "t1_jump"};
    tbl[2]  = '{mk_in(0, 0, 0, 0, 0, '0, 0, 0, 0), o0, "t1_after"};
    tbl[3]  = '{mk_in(0, 0, 0, 0, 1, '0, 1, 5, 5), osb, "t2_lu_rs2"};
    tbl[4]  = '{mk_in(0, 0, 0, 0, 1, '0, 0, 0, 0), o0, "t2_rd0"};
    tbl[5]  = '{mk_in(0, 0, 0, 0, 1, '0, 7, 2, 7), osb, "t2_lu_rs1"};
    tbl[6]  = '{mk_in(0, 0, 0, 0, 0, '0, 7, 2, 7), o0, "t2_noload"};
    tbl[7]  = '{mk_in(0, 1, 1, 0, 0, 32'h100, 0, 0, 0), ost, "t3_c1"};
    tbl[8]  = '{mk_in(0, 1, 1, 0, 0, 32'h200, 0, 0, 0), ost, "t3_c2"};
    tbl[9]  = '{mk_in(0, 0, 1, 0, 0, '0, 0, 0, 0), ost, "t3_c3"};
    tbl[10] = '{mk_in(0, 0, 0, 0, 0, '0, 0, 0, 0),
                mk_out(0, 0, 1, 1, 1, 0, 32'h100), "t3_replay"};
    tbl[11] = '{mk_in(0, 0, 0, 0, 0, '0, 0, 0, 0), o0, "t3_after"};
    tbl[12] = '{mk_in(0, 1, 1, 0, 0, 32'h300, 0, 0, 0), ost, "t5_latch"};
    tbl[13] = '{mk_in(1, 0, 1, 0, 0, '0, 0, 0, 0), o0, "t5_rst"};
    tbl[14] = '{mk_in(0, 0, 0, 0, 0, '0, 0, 0, 0), o0, "t5_no_redirect"};
    tbl[15] = '{mk_in(0, 1, 0, 0, 0, 32'h400, 0, 0, 0),
                mk_out(0, 0, 1, 1, 1, 0, 32'h400), "t5_jump"};
    tbl[16] = '{mk_in(0, 0, 1, 0, 0, '0, 0, 0, 0), ost, "hold_enter"};
    tbl[17] = '{mk_in(0, 0, 1, 0, 1, '0, 3, 0, 3), ost, "hold_over_lu"};
    tbl[18] = '{mk_in(0, 1, 0, 0, 0, 32'h500, 0, 0, 0),
                mk_out(0, 0, 1, 1, 1, 0, 32'h500), "hold_release_jump"};
    tbl[19] = '{mk_in(0, 0, 1, 0, 0, '0, 0, 0, 0), ost, "hold_enter2"};
    tbl[20] = '{mk_in(0, 0, 0, 0, 1, '0, 4, 4, 4), osb, "hold_release_lu"};
    tbl[21] = '{mk_in(0, 1, 1, 0, 1, 32'h600, 6, 0, 6), ost, "pend_latch"};
    tbl[22] = '{mk_in(0, 1, 0, 0, 1, 32'h700, 6, 0, 6),
                mk_out(0, 0, 1, 1, 1, 0, 32'h600), "pend_release"};
    tbl[23] = '{mk_in(0, 0, 0, 0, 0, '0, 0, 0, 0), o0, "pend_after"};

    for (int k = 0; k < 24; k++) run_cycle(tbl[k].i, tbl[k].e, tbl[k].nm);

    // Halt with a simultaneous jump, then 100 parked cycles, then reset.
    run_cycle(mk_in(0, 1, 0, 1, 0, 32'h1234, 0, 0, 0), osb, "halt_req");
    for (int k = 0; k < 100; k++) begin
      v = mk_in(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      run_cycle(v, oht, "halted");
    end
    run_cycle(mk_in(1, 0, 0, 0, 0, '0, 0, 0, 0), o0, "halt_rst");
    run_cycle(mk_in(0, 0, 0, 0, 0, '0, 0, 0, 0), o0, "halt_after_rst");

`ifdef PIPE_CTRL_PERF_EN
    // Counters from a clean reset: 4 hold cycles, one load-use, one jump.
    run_cycle(mk_in(1, 0, 0, 0, 0, '0, 0, 0, 0), o0, "perf_rst");
    for (int k = 0; k < 4; k++) run_cycle(mk_in(0, 0, 1, 0, 0, '0, 0, 0, 0), ost, "perf_hold");
    run_cycle(mk_in(0, 0, 0, 0, 0, '0, 0, 0, 0), o0, "perf_release");
    run_cycle(mk_in(0, 0, 0, 0, 1, '0, 9, 0, 9), osb, "perf_lu");
    run_cycle(mk_in(0, 1, 0, 0, 0, 32'h40, 0, 0, 0),
              mk_out(0, 0, 1, 1, 1, 0, 32'h40), "perf_jump");
    n_chk++;
    if (stall_cnt_o !== PW'(5) || flush_cnt_o !== PW'(2)) begin
      n_err++;
      $display("FAIL perf_totals: got stall=%0d flush=%0d, expected stall=5 flush=2",
               stall_cnt_o, flush_cnt_o);
    end
`endif

    // Random traffic against the model.
    run_cycle(mk_in(1, 0, 0, 0, 0, '0, 0, 0, 0), o0, "rand_rst");
    for (int k = 0; k < 3000; k++) begin
      v = mk_in(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 59) == 0),
                1'($urandom), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      run_cycle(v, model_eval(v), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
